// File: rtl/mcpu_alu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mcpu_alu_ctrl_if
// Purpose  : Bundles the instruction handshake, the ALU drive/return bus and
//            the write-back strobe of the MCPU ALU controller.
// Ports    : instr_*      - instruction offer / accept handshake and fields
//            alu_*        - registered operands to the ALU, result/overflow back
//            wb_*         - register-write notification pulse
// Modports : master - instruction source and ALU side (testbench / datapath)
//            slave  - the controller itself
// Revision : 1.0 - initial release
// ============================================================================
interface mcpu_alu_ctrl_if #(
  parameter int CMD_SIZE  = 2,
  parameter int WORD_SIZE = 8,
  parameter int REG_AW    = 2
);
  logic                 instr_valid;
  logic                 instr_ready;
  logic                 instr_ld;
  logic [CMD_SIZE-1:0]  instr_op;
  logic [REG_AW-1:0]    instr_rd;
  logic [REG_AW-1:0]    instr_rs1;
  logic [REG_AW-1:0]    instr_rs2;
  logic [WORD_SIZE-1:0] instr_imm;

  logic [CMD_SIZE-1:0]  alu_opcode;
  logic [WORD_SIZE-1:0] alu_r1;
  logic [WORD_SIZE-1:0] alu_r2;
  logic [WORD_SIZE-1:0] alu_out;
  logic                 alu_ovf;

  logic                 wb_valid;
  logic [REG_AW-1:0]    wb_addr;
  logic [WORD_SIZE-1:0] wb_data;

  modport master (
    output instr_valid, instr_ld, instr_op, instr_rd, instr_rs1, instr_rs2,
           instr_imm, alu_out, alu_ovf,
    input  instr_ready, alu_opcode, alu_r1, alu_r2, wb_valid, wb_addr, wb_data
  );

  modport slave (
    input  instr_valid, instr_ld, instr_op, instr_rd, instr_rs1, instr_rs2,
           instr_imm, alu_out, alu_ovf,
    output instr_ready, alu_opcode, alu_r1, alu_r2, wb_valid, wb_addr, wb_data
  );
endinterface
`default_nettype wire

// File: rtl/mcpu_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mcpu_alu_ctrl
// Purpose  : Small sequencer for an external combinational ALU. Holds a
//            2**REG_AW entry register file, accepts load-immediate or ALU
//            instructions, drives registered operands to the ALU, captures
//            the result and writes it back, keeping a sticky overflow flag.
// Ports    : clk      - rising-edge clock
//            rst_n    - asynchronous active-low reset
//            bus      - instruction / ALU / write-back bundle (slave side)
//            clr_ovf  - synchronous clear of ovf_flag (a same-cycle set wins)
//            ovf_flag - sticky ALU overflow
//            rd_addr  - combinational register-file read address
//            rd_data  - current contents of RF[rd_addr]
// Revision : 1.0 - initial release
// ============================================================================
module mcpu_alu_ctrl #(
  parameter int CMD_SIZE  = 2,
  parameter int WORD_SIZE = 8,
  parameter int REG_AW    = 2
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  mcpu_alu_ctrl_if.slave            bus,
  input  wire logic                 clr_ovf,
  output logic                      ovf_flag,
  input  wire logic [REG_AW-1:0]    rd_addr,
  output logic [WORD_SIZE-1:0]      rd_data
);

  localparam int NREG = 1 << REG_AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [REG_AW-1:0]    rd_q, rd_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic                 is_alu_q, is_alu_d;
  logic                 ovf_cap_q, ovf_cap_d;
  logic [CMD_SIZE-1:0]  alu_opcode_q, alu_opcode_d;
  logic [WORD_SIZE-1:0] alu_r1_q, alu_r1_d;
  logic [WORD_SIZE-1:0] alu_r2_q, alu_r2_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [REG_AW-1:0]    wb_addr_q, wb_addr_d;
  logic [WORD_SIZE-1:0] wb_data_q, wb_data_d;
  logic                 ovf_flag_q, ovf_flag_d;
  logic                 rf_we;
  logic [WORD_SIZE-1:0] rf_q [NREG];

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    rd_d         = rd_q;
    data_d       = data_q;
    is_alu_d     = is_alu_q;
    ovf_cap_d    = ovf_cap_q;
    alu_opcode_d = alu_opcode_q;
    alu_r1_d     = alu_r1_q;
    alu_r2_d     = alu_r2_q;
    wb_valid_d   = 1'b0;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    rf_we        = 1'b0;
    bus.instr_ready = 1'b0;

    case (state_q)
      IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) begin
          rd_d = bus.instr_rd;
          if (bus.instr_ld) begin
            data_d    = bus.instr_imm;
            is_alu_d  = 1'b0;
            ovf_cap_d = 1'b0;
            state_d   = WB;
          end else begin
            // Operands are read here, so a source equal to the destination
            // sees the value from before this instruction's write-back.
            alu_opcode_d = bus.instr_op;
            alu_r1_d     = rf_q[bus.instr_rs1];
            alu_r2_d     = rf_q[bus.instr_rs2];
            is_alu_d     = 1'b1;
            state_d      = EXEC;
          end
        end
      end
      EXEC: begin
        // One cycle for the external ALU to settle on the registered operands.
        data_d    = bus.alu_out;
        ovf_cap_d = bus.alu_ovf;
        state_d   = WB;
      end
      WB: begin
        // The register write and the wb_* pulse take effect on the edge that
        // leaves WB, so a reset during WB discards the instruction.
        rf_we      = 1'b1;
        wb_valid_d = 1'b1;
        wb_addr_d  = rd_q;
        wb_data_d  = data_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky overflow: the clear is applied first so a same-cycle set wins.
  always_comb begin
    ovf_flag_d = ovf_flag_q;
    if (clr_ovf) begin
      ovf_flag_d = 1'b0;
    end
    if (state_q == WB && is_alu_q && ovf_cap_q) begin
      ovf_flag_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Control and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rd_q         <= '0;
      data_q       <= '0;
      is_alu_q     <= 1'b0;
      ovf_cap_q    <= 1'b0;
      alu_opcode_q <= '0;
      alu_r1_q     <= '0;
      alu_r2_q     <= '0;
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      ovf_flag_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_q         <= rd_d;
      data_q       <= data_d;
      is_alu_q     <= is_alu_d;
      ovf_cap_q    <= ovf_cap_d;
      alu_opcode_q <= alu_opcode_d;
      alu_r1_q     <= alu_r1_d;
      alu_r2_q     <= alu_r2_d;
      wb_valid_q   <= wb_valid_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      ovf_flag_q   <= ovf_flag_d;
    end
  end

  // --------------------------------------------------------------------------
  // Register file: one register per entry with a decoded write enable
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < NREG; g++) begin : g_rf
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rf_q[g] <= '0;
      end else if (rf_we && rd_q == REG_AW'(g)) begin
        rf_q[g] <= data_q;
      end
    end
  end

  assign rd_data        = rf_q[rd_addr];
  assign ovf_flag       = ovf_flag_q;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_r1     = alu_r1_q;
  assign bus.alu_r2     = alu_r2_q;
  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_addr    = wb_addr_q;
  assign bus.wb_data    = wb_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mcpu_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcpu_alu_ctrl
// Purpose  : Self-checking bench for mcpu_alu_ctrl. A behavioural ALU closes
//            the loop; a reference register file predicts each write-back,
//            which is queued at accept and compared when wb_valid pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcpu_alu_ctrl;

  localparam int CMD_SIZE  = 2;
  localparam int WORD_SIZE = 8;
  localparam int REG_AW    = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       ovf_flag;
  logic [1:0] rd_addr = 2'd0;
  logic [7:0] rd_data;

  mcpu_alu_ctrl_if #(.CMD_SIZE(CMD_SIZE), .WORD_SIZE(WORD_SIZE), .REG_AW(REG_AW)) bus ();

  mcpu_alu_ctrl #(.CMD_SIZE(CMD_SIZE), .WORD_SIZE(WORD_SIZE), .REG_AW(REG_AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .clr_ovf  (clr_ovf),
    .ovf_flag (ovf_flag),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  always #5 clk = ~clk;

  // Reference ALU: 00 AND, 01 OR, 10 XOR, 11 ADD (carry out = overflow)
  function automatic logic [8:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'd0:    alu_f = {1'b0, a & b};
      2'd1:    alu_f = {1'b0, a | b};
      2'd2:    alu_f = {1'b0, a ^ b};
      default: alu_f = {1'b0, a} + {1'b0, b};
    endcase
  endfunction

  assign {bus.alu_ovf, bus.alu_out} = alu_f(bus.alu_opcode, bus.alu_r1, bus.alu_r2);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  logic [7:0] mrf [4];
  int         last_waits;

  // Write-back monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.wb_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("wb_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("wb_addr", 32'(bus.wb_addr), 32'(mon_e.addr));
        chk("wb_data", 32'(bus.wb_data), 32'(mon_e.data));
        chk("wb_latency", 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  // Offers one instruction (instr_valid is left high afterwards) and returns
  // just after the accept edge with the accept cycle number.
  task automatic send(input logic ld, input logic [1:0] op, input logic [1:0] rd,
                      input logic [1:0] rs1, input logic [1:0] rs2,
                      input logic [7:0] imm, output int acc);
    int         waits;
    logic [8:0] res;
    exp_t       e;
    waits = 0;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr_ld    = ld;
    bus.instr_op    = op;
    bus.instr_rd    = rd;
    bus.instr_rs1   = rs1;
    bus.instr_rs2   = rs2;
    bus.instr_imm   = imm;
    while (bus.instr_ready !== 1'b1 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    last_waits = waits;
    if (waits >= 20) begin
      chk("accept_timeout", 32'd0, 32'd1);
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    if (ld) begin
      e.data = imm;
      e.due  = acc + 1;
    end else begin
      res    = alu_f(op, mrf[rs1], mrf[rs2]);
      e.data = res[7:0];
      e.due  = acc + 2;
      chk("alu_opcode", 32'(bus.alu_opcode), 32'(op));
      chk("alu_r1", 32'(bus.alu_r1), 32'(mrf[rs1]));
      chk("alu_r2", 32'(bus.alu_r2), 32'(mrf[rs2]));
    end
    e.addr = rd;
    q.push_back(e);
    mrf[rd] = e.data;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic check_rf_zero(input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      chk(tag, 32'(rd_data), 32'd0);
    end
  endtask

  initial begin
    int acc;
    int prev;
    bus.instr_valid = 1'b0;
    bus.instr_ld    = 1'b0;
    bus.instr_op    = 2'd0;
    bus.instr_rd    = 2'd0;
    bus.instr_rs1   = 2'd0;
    bus.instr_rs2   = 2'd0;
    bus.instr_imm   = 8'd0;
    for (int i = 0; i < 4; i++) mrf[i] = 8'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.instr_ready), 32'd1);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_wb_addr", 32'(bus.wb_addr), 32'd0);
    chk("rst_wb_data", 32'(bus.wb_data), 32'd0);
    chk("rst_alu_opcode", 32'(bus.alu_opcode), 32'd0);
    chk("rst_alu_r1", 32'(bus.alu_r1), 32'd0);
    chk("rst_alu_r2", 32'(bus.alu_r2), 32'd0);
    chk("rst_ovf", 32'(ovf_flag), 32'd0);
    check_rf_zero("rst_rf");
    rst_n = 1'b1;

    // Logic ops; the first load must be taken on the first edge after reset
    send(1'b1, 2'd0, 2'd1, 2'd0, 2'd0, 8'h0F, acc);
    chk("ready_after_reset", 32'(last_waits), 32'd0);
    send(1'b1, 2'd0, 2'd2, 2'd0, 2'd0, 8'h3C, acc);
    send(1'b0, 2'd0, 2'd3, 2'd1, 2'd2, 8'h00, acc);
    send(1'b0, 2'd1, 2'd3, 2'd1, 2'd2, 8'h00, acc);
    send(1'b0, 2'd2, 2'd3, 2'd1, 2'd2, 8'h00, acc);
    bus.instr_valid = 1'b0;
    drain();
    rd_addr = 2'd3;
    @(negedge clk);
    chk("xor_rf", 32'(rd_data), 32'h33);
    chk("no_ovf_logic", 32'(ovf_flag), 32'd0);

    // ADD overflow and clear
    send(1'b1, 2'd0, 2'd1, 2'd0, 2'd0, 8'hFF, acc);
    send(1'b1, 2'd0, 2'd2, 2'd0, 2'd0, 8'h01, acc);
    chk("load_no_ovf", 32'(ovf_flag), 32'd0);
    send(1'b0, 2'd3, 2'd0, 2'd1, 2'd2, 8'h00, acc);
    bus.instr_valid = 1'b0;
    drain();
    @(negedge clk);
    chk("add_ovf_set", 32'(ovf_flag), 32'd1);
    rd_addr = 2'd0;
    #1;
    chk("add_wrap_rf", 32'(rd_data), 32'h00);
    clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(ovf_flag), 32'd0);

    // Back-to-back loads with instr_valid held high
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      send(1'b1, 2'd0, 2'(i), 2'd0, 2'd0, 8'($urandom_range(0, 255)), acc);
      if (i > 0) begin
        chk("b2b_interval", 32'(acc - prev), 32'd2);
        chk("b2b_ready_low_wb", 32'(last_waits), 32'd1);
      end
      prev = acc;
    end
    bus.instr_valid = 1'b0;
    drain();

    // Source equals destination, read port visibility
    rd_addr = 2'd2;
    send(1'b1, 2'd0, 2'd2, 2'd0, 2'd0, 8'h05, acc);
    send(1'b0, 2'd3, 2'd2, 2'd2, 2'd2, 8'h00, acc);
    bus.instr_valid = 1'b0;
    drain();
    @(negedge clk);
    chk("rs_eq_rd_read", 32'(rd_data), 32'h0A);

    // Reset during EXEC of an overflowing ADD R1
    send(1'b1, 2'd0, 2'd1, 2'd0, 2'd0, 8'hFF, acc);
    send(1'b1, 2'd0, 2'd2, 2'd0, 2'd0, 8'h01, acc);
    send(1'b0, 2'd3, 2'd1, 2'd1, 2'd2, 8'h00, acc);
    bus.instr_valid = 1'b0;
    rst_n = 1'b0;
    q.delete();
    for (int i = 0; i < 4; i++) mrf[i] = 8'd0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_exec_no_wb", 32'(bus.wb_valid), 32'd0);
    end
    check_rf_zero("rst_exec_rf");
    chk("rst_exec_ovf", 32'(ovf_flag), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_exec_ready", 32'(bus.instr_ready), 32'd1);
    chk("rst_exec_ovf_after", 32'(ovf_flag), 32'd0);

    // clr_ovf in the same cycle as an overflowing write-back: set wins
    send(1'b1, 2'd0, 2'd1, 2'd0, 2'd0, 8'h80, acc);
    send(1'b1, 2'd0, 2'd2, 2'd0, 2'd0, 8'h80, acc);
    send(1'b0, 2'd3, 2'd3, 2'd1, 2'd2, 8'h00, acc);
    bus.instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    clr_ovf = 1'b0;
    chk("set_wins_clr", 32'(ovf_flag), 32'd1);
    drain();
    rd_addr = 2'd3;
    #1;
    chk("set_wins_rf", 32'(rd_data), 32'h00);

    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
